// File: rtl/upsizer_pkg.sv
// Shared types, width defaults and helpers for the upsizer_ctrl width upsizer.
package upsizer_pkg;

  localparam int DEF_S_DATA_WIDTH = 8;
  localparam int DEF_M_DATA_WIDTH = 32;

  typedef enum logic {
    ST_FILL = 1'b0,
    ST_FULL = 1'b1
  } state_e;

  // Ceiling log2; returns 0 for values <= 1.
  function automatic int clog2(input int value);
    int res;
    int v;
    res = 0;
    v   = value - 1;
    while (v > 0) begin
      res = res + 1;
      v   = v >> 1;
    end
    return res;
  endfunction

endpackage

// File: rtl/upsizer_beat_cnt.sv
// Lane index counter for the upsizer: counts accepted beats within one word
// and saturates at RATIO-1. clr has priority over inc so a closing beat
// leaves the counter at lane 0 for the next word.
module upsizer_beat_cnt
  import upsizer_pkg::*;
#(
  parameter int RATIO = 4,
  parameter int CNT_W = 2
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             inc,
  input  logic             clr,
  output logic [CNT_W-1:0] cnt,
  output logic             at_max
);

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(RATIO - 1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Next count: clear wins, otherwise step while below the last lane.
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (inc && (cnt_q != CNT_MAX)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Count register with synchronous reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt    = cnt_q;
  assign at_max = (cnt_q == CNT_MAX);

endmodule

// File: rtl/upsizer_ctrl.sv
// Width upsizer: packs RATIO narrow slave beats into one wide master word,
// beat k landing in lane k (lane 0 = MSBs). Owns valid/ready on both sides.
// Optional feature macro: UPSIZER_LAST_EN adds s_last/m_keep/m_last and lets
// a beat flagged s_last close a word early with unwritten lanes zeroed.
module upsizer_ctrl
  import upsizer_pkg::*;
#(
  parameter int S_DATA_WIDTH = DEF_S_DATA_WIDTH,
  parameter int M_DATA_WIDTH = DEF_M_DATA_WIDTH,
  localparam int RATIO = M_DATA_WIDTH / S_DATA_WIDTH,
  localparam int CNT_W = (clog2(RATIO) < 1) ? 1 : clog2(RATIO)
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    s_val,
  output logic                    s_rdy,
  input  logic [S_DATA_WIDTH-1:0] s_data,
  output logic                    m_val,
  input  logic                    m_rdy,
  output logic [M_DATA_WIDTH-1:0] m_data
`ifdef UPSIZER_LAST_EN
  ,
  input  logic                    s_last,
  output logic [RATIO-1:0]        m_keep,
  output logic                    m_last
`endif
);

  state_e                  state_q, state_d;
  logic                    m_val_q;
  logic [M_DATA_WIDTH-1:0] data_q, data_d;
  logic [RATIO-1:0]        keep_q, keep_d;
  logic                    last_q, last_d;
  logic [CNT_W-1:0]        cnt;
  logic                    at_max;
  logic                    accept;
  logic                    close;
  logic                    last_beat;

`ifdef UPSIZER_LAST_EN
  assign last_beat = s_last;
`else
  assign last_beat = 1'b0;
`endif

  // A word closes on its final lane, or early on a flagged last beat.
  assign accept = s_val && s_rdy;
  assign close  = accept && (at_max || last_beat);

  upsizer_beat_cnt #(
    .RATIO (RATIO),
    .CNT_W (CNT_W)
  ) u_beat_cnt (
    .clock  (clock),
    .reset  (reset),
    .inc    (accept),
    .clr    (close),
    .cnt    (cnt),
    .at_max (at_max)
  );

  // State register plus the registered master-side outputs.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= ST_FILL;
      m_val_q <= 1'b0;
      data_q  <= '0;
      keep_q  <= '0;
      last_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      m_val_q <= (state_d == ST_FULL);
      data_q  <= data_d;
      keep_q  <= keep_d;
      last_q  <= last_d;
    end
  end

  // Next state. In FULL an accepted beat means the word was consumed in the
  // same cycle, so FULL->FULL only happens for a single-beat early close.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_FILL: if (close) state_d = ST_FULL;
      ST_FULL: if (m_rdy) state_d = close ? ST_FULL : ST_FILL;
      default: state_d = ST_FILL;
    endcase
  end

  // Slave ready: always open while filling, follows the consumer when full.
  always_comb begin
    s_rdy = 1'b0;
    if (!reset) begin
      s_rdy = (state_q == ST_FILL) || m_rdy;
    end
  end

  // Lane write for an accepted beat; lanes are frozen while waiting on m_rdy.
  always_comb begin
    data_d = data_q;
    keep_d = keep_q;
    last_d = last_q;
    if (accept) begin
`ifdef UPSIZER_LAST_EN
      if (cnt == '0) begin
        data_d = '0;
        keep_d = '0;
      end
`endif
      for (int k = 0; k < RATIO; k++) begin
        if (cnt == CNT_W'(k)) begin
          data_d[M_DATA_WIDTH-1-k*S_DATA_WIDTH -: S_DATA_WIDTH] = s_data;
          keep_d[RATIO-1-k] = 1'b1;
        end
      end
      last_d = last_beat;
    end
  end

  assign m_val  = m_val_q;
  assign m_data = data_q;

`ifdef UPSIZER_LAST_EN
  assign m_keep = keep_q;
  assign m_last = last_q;
`else
  logic unused_keep;
  assign unused_keep = ^{keep_q, last_q};
`endif

endmodule

// File: tb/tb_upsizer_ctrl.sv
// Self-checking bench for upsizer_ctrl (RATIO = 4). Expected words are pushed
// into a scoreboard queue; a negedge monitor pops on every master handshake.
module tb_upsizer_ctrl;

  typedef struct {
    logic [31:0] data;
    logic [3:0]  keep;
    logic        last;
  } exp_t;

  logic        clock;
  logic        reset;
  logic        s_val;
  logic        s_rdy;
  logic [7:0]  s_data;
  logic        m_val;
  logic        m_rdy;
  logic [31:0] m_data;
  logic        s_last;
`ifdef UPSIZER_LAST_EN
  logic [3:0]  m_keep;
  logic        m_last;
`endif

  int   checks;
  int   errors;
  int   stalls;
  exp_t sb[$];

  upsizer_ctrl #(
    .S_DATA_WIDTH (8),
    .M_DATA_WIDTH (32)
  ) dut (
    .clock  (clock),
    .reset  (reset),
    .s_val  (s_val),
    .s_rdy  (s_rdy),
    .s_data (s_data),
    .m_val  (m_val),
    .m_rdy  (m_rdy),
    .m_data (m_data)
`ifdef UPSIZER_LAST_EN
    ,
    .s_last (s_last),
    .m_keep (m_keep),
    .m_last (m_last)
`endif
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic push(input logic [31:0] d, input logic [3:0] k, input logic l);
    exp_t e;
    e.data = d;
    e.keep = k;
    e.last = l;
    sb.push_back(e);
  endtask

  // Present one beat and hold it until the DUT takes it (bounded wait).
  task automatic send(input logic [7:0] d, input logic l);
    int n;
    n      = 0;
    s_val  = 1'b1;
    s_data = d;
    s_last = l;
    forever begin
      @(negedge clock);
      if (s_rdy) break;
      stalls++;
      n++;
      if (n > 50) begin
        checks++;
        errors++;
        $display("FAIL send_timeout: beat 0x%0h not accepted within 50 cycles", d);
        break;
      end
    end
    @(posedge clock);
    #1;
    s_val  = 1'b0;
    s_last = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clock);
    end
    #1;
  endtask

  // Monitor: a word is consumed at the posedge following a negedge where
  // m_val && m_rdy hold, since inputs only change just after posedges.
  always @(negedge clock) begin
    if (!reset && m_val && m_rdy) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_word: got 0x%0h expected no word", m_data);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("word_data", m_data, e.data);
`ifdef UPSIZER_LAST_EN
        check("word_keep", 32'(m_keep), 32'(e.keep));
        check("word_last", 32'(m_last), 32'(e.last));
`endif
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    checks = 0;
    errors = 0;
    stalls = 0;
    reset  = 1'b1;
    s_val  = 1'b0;
    s_data = 8'h00;
    s_last = 1'b0;
    m_rdy  = 1'b1;

    // Reset state
    @(negedge clock);
    check("rst_s_rdy", 32'(s_rdy), 32'd0);
    idle(2);
    reset = 1'b0;
    check("rst_m_val", 32'(m_val), 32'd0);
    check("rst_m_data", m_data, 32'h0);
    idle(1);

    // 1. Basic pack
    push(32'h11223344, 4'b1111, 1'b0);
    stalls = 0;
    send(8'h11, 1'b0);
    send(8'h22, 1'b0);
    send(8'h33, 1'b0);
    check("basic_m_val_before_last", 32'(m_val), 32'd0);
    send(8'h44, 1'b0);
    check("basic_m_val_after_last", 32'(m_val), 32'd1);
    check("basic_no_stall", 32'(stalls), 32'd0);
    idle(1);
    check("basic_m_val_drop", 32'(m_val), 32'd0);

    // 2. Backpressure then consume-and-accept in one cycle
    m_rdy = 1'b0;
    push(32'h0A0B0C0D, 4'b1111, 1'b0);
    send(8'h0A, 1'b0);
    send(8'h0B, 1'b0);
    send(8'h0C, 1'b0);
    send(8'h0D, 1'b0);
    s_val  = 1'b1;
    s_data = 8'h55;
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      check("bp_s_rdy", 32'(s_rdy), 32'd0);
      check("bp_m_val", 32'(m_val), 32'd1);
      check("bp_m_data", m_data, 32'h0A0B0C0D);
    end
    @(posedge clock);
    #1;
    m_rdy = 1'b1;
    push(32'h55667788, 4'b1111, 1'b0);
    @(negedge clock);
    check("bp_release_s_rdy", 32'(s_rdy), 32'd1);
    @(posedge clock);
    #1;
    s_val = 1'b0;
    check("bp_no_bubble_fill", 32'(m_val), 32'd0);
    send(8'h66, 1'b0);
    send(8'h77, 1'b0);
    send(8'h88, 1'b0);
    idle(1);

    // 3. Streaming two words
    push(32'h01020304, 4'b1111, 1'b0);
    push(32'h05060708, 4'b1111, 1'b0);
    stalls = 0;
    for (int i = 1; i <= 8; i++) begin
      send(8'(i), 1'b0);
    end
    check("stream_no_stall", 32'(stalls), 32'd0);
    idle(1);

    // 4. Gapped beats
    push(32'hA0A1A2A3, 4'b1111, 1'b0);
    for (int i = 0; i < 4; i++) begin
      send(8'hA0 + 8'(i), 1'b0);
      if (i < 3) idle(2);
    end
    idle(1);

    // 5. Reset mid-word
    send(8'hB0, 1'b0);
    send(8'hB1, 1'b0);
    reset = 1'b1;
    @(negedge clock);
    check("midrst_s_rdy", 32'(s_rdy), 32'd0);
    @(posedge clock);
    #1;
    reset = 1'b0;
    check("midrst_m_val", 32'(m_val), 32'd0);
    check("midrst_m_data", m_data, 32'h0);
    push(32'hC0C1C2C3, 4'b1111, 1'b0);
    send(8'hC0, 1'b0);
    send(8'hC1, 1'b0);
    send(8'hC2, 1'b0);
    send(8'hC3, 1'b0);
    idle(1);

`ifdef UPSIZER_LAST_EN
    // 6. Early close with s_last, then full words with and without last
    push(32'hAABB0000, 4'b1100, 1'b1);
    send(8'hAA, 1'b0);
    send(8'hBB, 1'b1);
    push(32'hCCDDEEFF, 4'b1111, 1'b1);
    send(8'hCC, 1'b0);
    send(8'hDD, 1'b0);
    send(8'hEE, 1'b0);
    send(8'hFF, 1'b1);
    push(32'h12345678, 4'b1111, 1'b0);
    send(8'h12, 1'b0);
    send(8'h34, 1'b0);
    send(8'h56, 1'b0);
    send(8'h78, 1'b0);
    idle(1);
`endif

    // Drain: every expected word must have been observed.
    n = 0;
    while (sb.size() != 0 && n < 50) begin
      idle(1);
      n++;
    end
    check("scoreboard_drained", 32'(sb.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
